// File: rtl/tt_um_serial_subtractor_pkg.sv
// Shared constants and types for the bit-serial subtractor tile.
package tt_sub_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned LOAD_A_BIT = 0;
  localparam int unsigned LOAD_B_BIT = 1;
  localparam int unsigned START_BIT  = 2;
  localparam int unsigned BUSY_BIT   = 3;
  localparam int unsigned DONE_BIT   = 4;
  localparam int unsigned BORROW_BIT = 5;

  localparam logic [7:0] UIO_OE_VAL = 8'b0011_1000;

endpackage

// File: rtl/tt_um_serial_subtractor_if.sv
// TinyTapeout user-tile pin frame (enable plus data/control buses).
interface tt_um_serial_subtractor_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/tt_um_serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial 8-bit subtractor tile: byte-wide operand loads, LSB-first borrow chain.
module tt_um_serial_subtractor
  import tt_sub_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  tt_um_serial_subtractor_if.slave  bus
);

  state_t             state;
  logic [WIDTH-1:0]   reg_a;
  logic [WIDTH-1:0]   reg_b;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   result_q;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic               borrow_out_q;
  logic               busy_q;
  logic               done_q;

  logic               d_c;
  logic               bout_c;
  logic               load_a_c;
  logic               load_b_c;
  logic               start_c;
  logic               last_bit_c;
  logic               unused_ok;

  assign load_a_c   = bus.uio_in[LOAD_A_BIT];
  assign load_b_c   = bus.uio_in[LOAD_B_BIT];
  assign start_c    = bus.uio_in[START_BIT];
  assign last_bit_c = (cnt == CNT_W'(WIDTH - 1));
  assign unused_ok  = &{1'b0, bus.uio_in[7:3]};

  full_subtractor_cell u_cell (
    .a    (reg_a[0]),
    .b    (reg_b[0]),
    .bin  (borrow),
    .d    (d_c),
    .bout (bout_c)
  );

  // Control FSM with datapath; ena low freezes every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      reg_a        <= '0;
      reg_b        <= '0;
      shift_q      <= '0;
      result_q     <= '0;
      cnt          <= '0;
      borrow       <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (bus.ena) begin
      case (state)
        IDLE, DONE: begin
          if (start_c) begin
            state   <= RUN;
            cnt     <= '0;
            borrow  <= 1'b0;
            shift_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            if (load_a_c) reg_a <= bus.ui_in;
            if (load_b_c) reg_b <= bus.ui_in;
            if (load_a_c || load_b_c) done_q <= 1'b0;
          end
        end
        RUN: begin
          reg_a   <= reg_a >> 1;
          reg_b   <= reg_b >> 1;
          shift_q <= {d_c, shift_q[WIDTH-1:1]};
          borrow  <= bout_c;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit_c) begin
            state        <= DONE;
            result_q     <= {d_c, shift_q[WIDTH-1:1]};
            borrow_out_q <= bout_c;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Status bits on the bidirectional pins; all other bits stay low.
  always_comb begin
    bus.uio_out             = '0;
    bus.uio_out[BUSY_BIT]   = busy_q;
    bus.uio_out[DONE_BIT]   = done_q;
    bus.uio_out[BORROW_BIT] = borrow_out_q;
  end

  assign bus.uo_out = result_q;
  assign bus.uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Self-checking bench for the bit-serial subtractor tile.
module tb_tt_um_serial_subtractor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tt_um_serial_subtractor_if bus ();

  tt_um_serial_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    bus.ui_in  = a;
    bus.uio_in = 8'h01;
    step();
    bus.ui_in  = b;
    bus.uio_in = 8'h02;
    step();
    bus.uio_in = 8'h00;
  endtask

  task automatic start_op();
    bus.uio_in = 8'h04;
    step();
    bus.uio_in = 8'h00;
  endtask

  // Steps until busy drops; returns the number of edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.uio_out[3] === 1'b1 && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic run_check(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_d, input logic exp_bo);
    int n;
    load_ops(a, b);
    start_op();
    check({name, " busy"}, 32'(bus.uio_out[3]), 32'd1);
    wait_done(n);
    check({name, " cycles"}, 32'(n), 32'd8);
    check({name, " done"}, 32'(bus.uio_out[4]), 32'd1);
    check({name, " diff"}, 32'(bus.uo_out), 32'(exp_d));
    check({name, " borrow"}, 32'(bus.uio_out[5]), 32'(exp_bo));
  endtask

  initial begin
    int n;
    int ra;
    int rb;
    logic [7:0] res_hold;
    checks = 0;
    errors = 0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    step();
    step();
    check("reset uo_out", 32'(bus.uo_out), 32'h0);
    check("reset uio_out", 32'(bus.uio_out), 32'h0);
    check("uio_oe", 32'(bus.uio_oe), 32'h38);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed table with hand-computed expectations
    vecs.push_back('{8'h5A, 8'h23, 8'h37, 1'b0});
    vecs.push_back('{8'h10, 8'h20, 8'hF0, 1'b1});
    vecs.push_back('{8'hFF, 8'h01, 8'hFE, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 8'h01, 8'hFF, 1'b1});
    vecs.push_back('{8'h80, 8'h01, 8'h7F, 1'b0});
    vecs.push_back('{8'h01, 8'hFF, 8'h02, 1'b1});
    foreach (vecs[i]) run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);

    // Done holds and result stays stable while idle
    run_check("hold", 8'h10, 8'h20, 8'hF0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold done", 32'(bus.uio_out[4]), 32'd1);
      check("hold diff", 32'(bus.uo_out), 32'hF0);
    end
    bus.ui_in  = 8'h77;
    bus.uio_in = 8'h01;
    step();
    bus.uio_in = 8'h00;
    check("load clears done", 32'(bus.uio_out[4]), 32'd0);
    check("load keeps diff", 32'(bus.uo_out), 32'hF0);

    // Restart without reload consumes emptied operands: 0 - 0
    run_check("pre-restart", 8'hFF, 8'h01, 8'hFE, 1'b0);
    start_op();
    wait_done(n);
    check("restart cycles", 32'(n), 32'd8);
    check("restart diff", 32'(bus.uo_out), 32'h00);
    check("restart borrow", 32'(bus.uio_out[5]), 32'd0);

    // Controls during RUN are ignored
    load_ops(8'h80, 8'h01);
    start_op();
    step();
    step();
    bus.ui_in  = 8'hAA;
    bus.uio_in = 8'h05;
    step();
    bus.ui_in  = 8'h55;
    bus.uio_in = 8'h06;
    step();
    bus.uio_in = 8'h00;
    wait_done(n);
    check("ignore cycles", 32'(n + 4), 32'd8);
    check("ignore diff", 32'(bus.uo_out), 32'h7F);
    check("ignore borrow", 32'(bus.uio_out[5]), 32'd0);

    // ena low freezes the run for exactly four cycles
    load_ops(8'h33, 8'h11);
    start_op();
    step();
    step();
    res_hold   = bus.uo_out;
    bus.ena    = 1'b0;
    bus.uio_in = 8'h04;
    for (int i = 0; i < 4; i++) begin
      step();
      check("freeze busy", 32'(bus.uio_out[3]), 32'd1);
      check("freeze done", 32'(bus.uio_out[4]), 32'd0);
      check("freeze diff", 32'(bus.uo_out), 32'(res_hold));
    end
    bus.uio_in = 8'h00;
    bus.ena    = 1'b1;
    wait_done(n);
    check("freeze cycles", 32'(n + 2), 32'd8);
    check("freeze result", 32'(bus.uo_out), 32'h22);

    // Asynchronous reset mid-run
    load_ops(8'h5A, 8'h23);
    start_op();
    for (int i = 0; i < 5; i++) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst uo_out", 32'(bus.uo_out), 32'h0);
    check("arst uio_out", 32'(bus.uio_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_check("post-reset", 8'h09, 8'h04, 8'h05, 1'b0);

    // Random operands against arithmetic reference
    for (int i = 0; i < 24; i++) begin
      ra = int'($urandom_range(255));
      rb = int'($urandom_range(255));
      run_check($sformatf("rand%0d", i), 8'(ra), 8'(rb), 8'((ra - rb + 256) % 256), ra < rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
